// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
      return clk_freq_hz / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; the head entry is always visible on pop_data_o.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   output logic                     full_o,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;

   // A pop frees the slot the push lands in, so a full FIFO still accepts a push when popped.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/uart_rx_bridge.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling FSM, FWFT byte FIFO, framing/overrun flags.
//  state | meaning
//  IDLE  | line high, waiting for a start edge
//  START | half-bit wait, confirm start bit (reject glitches)
//  DATA  | sample 8 data bits LSB-first at bit centres
//  STOP  | sample stop bit, push byte or flag framing error
//  BREAK | line held low after framing error, wait for high
`timescale 1ns/1ps
module uart_rx_bridge
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxd_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   input  logic       overrun_clr_i,
   output logic       busy_o
);

   localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CNT_W = $clog2(CPB);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int FAW   = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

   rx_state_t              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic [1:0]             sync_q;
   logic                   rxs, cnt_zero, push, pop;
   logic                   fifo_full, fifo_empty;
   logic [7:0]             fifo_data;
   logic [FAW:0]           fifo_count;

   assign rxs      = sync_q[1];
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs) begin
               cnt_d   = HALF_LOAD;
               state_d = START;
            end
         end
         START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs) begin
               state_d = IDLE;
            end else begin
               cnt_d   = FULL_LOAD;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               cnt_d   = FULL_LOAD;
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + 1'b1;
            end
         end
         STOP: begin
            // Leaving mid-stop-bit lets the next start edge be caught without an idle gap.
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = BREAK;
            end
         end
         BREAK: begin
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop       = rx_valid_o & rx_ready_i;
   assign overrun_d = (push & fifo_full & ~pop) | (overrun_q & ~overrun_clr_i);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rxd_i};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .push_i      (push),
      .push_data_i (shift_q),
      .full_o      (fifo_full),
      .pop_i       (pop),
      .pop_data_o  (fifo_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign rx_valid_o  = (fifo_count != '0);
   assign rx_byte_o   = fifo_empty ? 8'h00 : fifo_data;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Scenario bench for uart_rx_bridge at 10 clocks per bit; popped bytes are matched against a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_bridge;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rxd_i;
   logic [7:0] rx_byte_o;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       overrun_clr_i;
   logic       busy_o;

   int         checks = 0;
   int         failures = 0;
   int         valid_cycles = 0;
   int         fe_cnt = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   uart_rx_bridge #(
      .CLK_FREQ_HZ (1000000),
      .BAUD_RATE   (100000),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .rxd_i         (rxd_i),
      .rx_byte_o     (rx_byte_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .frame_err_o   (frame_err_o),
      .overrun_o     (overrun_o),
      .overrun_clr_i (overrun_clr_i),
      .busy_o        (busy_o)
   );

   // Monitor: every accepted byte must be the oldest outstanding expected byte.
   always @(negedge clk) begin
      if (rx_valid_o) valid_cycles++;
      if (frame_err_o) fe_cnt++;
      if (rx_valid_o && rx_ready_i) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte got=%02h expected=none", rx_byte_o);
         end else begin
            exp_b = sb.pop_front();
            if (rx_byte_o !== exp_b) begin
               failures++;
               $display("FAIL rx_byte got=%02h expected=%02h", rx_byte_o, exp_b);
            end
         end
      end
   end

   // Called right after a posedge; each bit lasts 10 clocks and the task returns on a posedge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push);
      if (expect_push) sb.push_back(b);
      #1 rxd_i = 1'b0;
      repeat (10) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rxd_i = b[i];
         repeat (10) @(posedge clk);
      end
      #1 rxd_i = stop;
      repeat (10) @(posedge clk);
      #1 rxd_i = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got=%03h expected=000",
                  {rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o});
      end
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
         failures++;
         $display("FAIL post_reset_idle got=%03h expected=000",
                  {rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o});
      end
      @(posedge clk);
   endtask

   task automatic test_single();
      int vc0, fe0, lat;
      vc0 = valid_cycles;
      fe0 = fe_cnt;
      lat = 0;
      #1 rx_ready_i = 1'b1;
      @(posedge clk);
      fork
         send_frame(8'h55, 1'b1, 1'b1);
         begin
            do begin
               @(posedge clk);
               lat++;
               #2;
            end while (!rx_valid_o && lat < 150);
         end
      join
      checks++;
      if (lat < 98 || lat > 100) begin
         failures++;
         $display("FAIL single_latency got=%0d expected=98..100", lat);
      end
      repeat (5) @(posedge clk);
      checks++;
      if (valid_cycles - vc0 != 1) begin
         failures++;
         $display("FAIL single_valid_width got=%0d expected=1", valid_cycles - vc0);
      end
      checks++;
      if (fe_cnt != fe0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL single_errors got=fe%0d/ov%b expected=fe0/ov0", fe_cnt - fe0, overrun_o);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL single_pending got=%0d expected=0", sb.size());
      end
   endtask

   task automatic test_glitch();
      int vc0, fe0, n;
      logic saw_busy;
      vc0 = valid_cycles;
      fe0 = fe_cnt;
      n = 0;
      #1 rxd_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rxd_i = 1'b1;
      saw_busy = busy_o;
      do begin
         @(posedge clk);
         n++;
         #2;
      end while (busy_o && n < 8);
      checks++;
      if (saw_busy !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL glitch_busy got=rise%b/end%b expected=rise1/end0", saw_busy, busy_o);
      end
      @(posedge clk);
      repeat (20) @(posedge clk);
      checks++;
      if (valid_cycles != vc0 || fe_cnt != fe0) begin
         failures++;
         $display("FAIL glitch_side_effects got=v%0d/fe%0d expected=v0/fe0",
                  valid_cycles - vc0, fe_cnt - fe0);
      end
   endtask

   task automatic test_framing();
      int vc0, fe0;
      vc0 = valid_cycles;
      fe0 = fe_cnt;
      send_frame(8'hA5, 1'b0, 1'b0);
      #1 rxd_i = 1'b0;
      repeat (40) @(posedge clk);
      #1 rxd_i = 1'b1;
      repeat (20) @(posedge clk);
      checks++;
      if (fe_cnt - fe0 != 1 || valid_cycles != vc0) begin
         failures++;
         $display("FAIL frame_err_pulses got=fe%0d/v%0d expected=fe1/v0",
                  fe_cnt - fe0, valid_cycles - vc0);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL break_exit got=%b expected=0", busy_o);
      end
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      checks++;
      if (sb.size() != 0 || fe_cnt - fe0 != 1) begin
         failures++;
         $display("FAIL after_break got=pending%0d/fe%0d expected=pending0/fe1",
                  sb.size(), fe_cnt - fe0);
      end
   endtask

   task automatic test_overrun();
      #1 rx_ready_i = 1'b0;
      @(posedge clk);
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, i <= 4);
         if (i == 4) begin
            checks++;
            if (overrun_o !== 1'b0) begin
               failures++;
               $display("FAIL full_no_overrun got=%b expected=0", overrun_o);
            end
         end
      end
      repeat (5) @(posedge clk);
      checks++;
      if (overrun_o !== 1'b1 || rx_valid_o !== 1'b1 || rx_byte_o !== 8'h01) begin
         failures++;
         $display("FAIL overrun_state got=ov%b/v%b/head%02h expected=ov1/v1/head01",
                  overrun_o, rx_valid_o, rx_byte_o);
      end
      #1 rx_ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0 || rx_valid_o !== 1'b0 || overrun_o !== 1'b1) begin
         failures++;
         $display("FAIL overrun_drain got=pending%0d/v%b/ov%b expected=pending0/v0/ov1",
                  sb.size(), rx_valid_o, overrun_o);
      end
      overrun_clr_i = 1'b1;
      @(posedge clk);
      #1 overrun_clr_i = 1'b0;
      checks++;
      if (overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear got=%b expected=0", overrun_o);
      end
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      checks++;
      if (sb.size() != 0 || fe_cnt != fe0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back got=pending%0d/fe%0d/ov%b expected=pending0/fe0/ov0",
                  sb.size(), fe_cnt - fe0, overrun_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int fe0;
      b = 8'h81;
      fe0 = fe_cnt;
      #1 rx_ready_i = 1'b0;
      @(posedge clk);
      send_frame(8'h77, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      checks++;
      if (rx_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_fill got=%b expected=1", rx_valid_o);
      end
      #1 rxd_i = 1'b0;
      repeat (10) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1 rxd_i = b[i];
         repeat (10) @(posedge clk);
      end
      #1 rxd_i = b[3];
      repeat (5) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
         failures++;
         $display("FAIL mid_frame_reset got=%03h expected=000",
                  {rx_valid_o, rx_byte_o, frame_err_o, overrun_o, busy_o});
      end
      repeat (3) @(posedge clk);
      #1 rxd_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (10) @(posedge clk);
      #1 rx_ready_i = 1'b1;
      checks++;
      if (rx_valid_o !== 1'b0 || busy_o !== 1'b0 || fe_cnt != fe0) begin
         failures++;
         $display("FAIL post_reset_clean got=v%b/busy%b/fe%0d expected=v0/busy0/fe0",
                  rx_valid_o, busy_o, fe_cnt - fe0);
      end
      @(posedge clk);
      send_frame(8'hC3, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL after_reset_rx got=pending%0d expected=0", sb.size());
      end
   endtask

   initial begin
      resetn        = 1'b0;
      rxd_i         = 1'b1;
      rx_ready_i    = 1'b0;
      overrun_clr_i = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
